// File: rtl/csr_file_m.sv
// Purpose : machine-mode CSR file (trap, interrupt, counter CSRs) for the commit stage.
// Latency : trap/mret decision, redirect and read data are combinational; state updates on the next edge.
// Backpr. : none; one event per cycle is resolved by priority exception > interrupt > mret > CSR write.
//
// Ports: csr_wen/csr_waddr/csr_wdata  CSR write from the committing instruction
//        csr_raddr/csr_rdata          read port, forwarded from an accepted same-cycle write
//        pc/next_pc/commit            committing instruction context
//        exc_valid/exc_cause/exc_tval synchronous exception
//        mret, irq_ext/soft/timer     trap return and level interrupt lines
//        hpm_event                    per-counter increment pulses
//        trap_take/redirect_*         trap entry / mret fetch redirect
//        irq_pending, mstatus_o, mie_o status taps
// Optional: define CSR_HPM_EN to implement NUM_HPM mhpmcounters at 0xB03 upward; otherwise
//           those addresses read 0, ignore writes, and hpm_event is ignored.
module csr_file_m #(
    parameter int              XLEN        = 64,
    parameter int              NUM_HPM     = 4,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              csr_wen,
    input  logic [11:0]       csr_waddr,
    input  logic [XLEN-1:0]   csr_wdata,
    input  logic [11:0]       csr_raddr,
    output logic [XLEN-1:0]   csr_rdata,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   next_pc,
    input  logic              commit,
    input  logic              exc_valid,
    input  logic [4:0]        exc_cause,
    input  logic [XLEN-1:0]   exc_tval,
    input  logic              mret,
    input  logic              irq_ext,
    input  logic              irq_soft,
    input  logic              irq_timer,
    input  logic [NUM_HPM-1:0] hpm_event,
    output logic              trap_take,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              irq_pending,
    output logic [XLEN-1:0]   mstatus_o,
    output logic [XLEN-1:0]   mie_o
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_HPM0     = 12'hB03;

    logic            mst_mie;
    logic            mst_mpie;
    logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0] mcycle_q, minstret_q;
    logic [XLEN-1:0] mstatus_val, mip_val, irq_vec, wval, rval, tvec_base, irq_cause;
    logic [3:0]      irq_code;
    logic            irq_take, mret_acc, wr_acc, retire;
`ifdef CSR_HPM_EN
    logic [XLEN-1:0] hpm_q [NUM_HPM];
`endif

    // The low two pc bits never reach mepc (IALIGN is 32).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[1:0], next_pc[1:0]};

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mst_mpie;
        mstatus_val[3]     = mst_mie;
        mip_val            = '0;
        mip_val[11]        = irq_ext;
        mip_val[7]         = irq_timer;
        mip_val[3]         = irq_soft;
    end

    assign irq_vec     = mip_val & mie_q;
    assign irq_pending = |irq_vec;

    always_comb begin
        if (irq_vec[11])     irq_code = 4'd11;
        else if (irq_vec[3]) irq_code = 4'd3;
        else                 irq_code = 4'd7;
        irq_cause           = '0;
        irq_cause[XLEN-1]   = 1'b1;
        irq_cause[3:0]      = irq_code;
    end

    assign irq_take       = !reset && commit && !exc_valid && mst_mie && irq_pending;
    assign trap_take      = !reset && (exc_valid || irq_take);
    assign mret_acc       = !reset && mret && !trap_take;
    assign wr_acc         = !reset && csr_wen && !trap_take && !mret_acc;
    assign retire         = commit && !exc_valid;
    assign redirect_valid = trap_take || mret_acc;
    assign mstatus_o      = mstatus_val;
    assign mie_o          = mie_q;

    // Post-WARL value of the pending write; also what the read port forwards.
    always_comb begin
        wval = '0;
        case (csr_waddr)
            A_MSTATUS: begin
                wval[12:11] = 2'b11;
                wval[7]     = csr_wdata[7];
                wval[3]     = csr_wdata[3];
            end
            A_MIE: begin
                wval[11] = csr_wdata[11];
                wval[7]  = csr_wdata[7];
                wval[3]  = csr_wdata[3];
            end
            // Reserved modes 2/3 collapse to direct mode.
            A_MTVEC:  wval = {csr_wdata[XLEN-1:2], csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
            A_MEPC:   wval = {csr_wdata[XLEN-1:2], 2'b00};
            A_MSCRATCH, A_MCAUSE, A_MTVAL, A_MCYCLE, A_MINSTRET: wval = csr_wdata;
            default:  wval = '0;
        endcase
`ifdef CSR_HPM_EN
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_waddr == A_HPM0 + 12'(i)) wval = csr_wdata;
        end
`endif
    end

    always_comb begin
        rval = '0;
        case (csr_raddr)
            A_MSTATUS:  rval = mstatus_val;
            A_MIE:      rval = mie_q;
            A_MTVEC:    rval = mtvec_q;
            A_MSCRATCH: rval = mscratch_q;
            A_MEPC:     rval = mepc_q;
            A_MCAUSE:   rval = mcause_q;
            A_MTVAL:    rval = mtval_q;
            A_MIP:      rval = mip_val;
            A_MCYCLE:   rval = mcycle_q;
            A_MINSTRET: rval = minstret_q;
            default:    rval = '0;
        endcase
`ifdef CSR_HPM_EN
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_raddr == A_HPM0 + 12'(i)) rval = hpm_q[i];
        end
`endif
    end

    // mip is a live view of the lines, so it is never forwarded.
    assign csr_rdata = (wr_acc && csr_waddr == csr_raddr && csr_raddr != A_MIP) ? wval : rval;

    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

    always_comb begin
        redirect_pc = mepc_q;
        if (trap_take) begin
            redirect_pc = tvec_base;
            if (!exc_valid && mtvec_q[1:0] == 2'b01)
                redirect_pc = tvec_base + XLEN'({irq_code, 2'b00});
        end else if (csr_wen && csr_waddr == A_MEPC) begin
            // mret sees the mepc value being written alongside it, even though the write is dropped.
            redirect_pc = {csr_wdata[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= {RESET_MTVEC[XLEN-1:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (trap_take) begin
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
                if (exc_valid) begin
                    mepc_q   <= {pc[XLEN-1:2], 2'b00};
                    mcause_q <= XLEN'(exc_cause);
                    mtval_q  <= exc_tval;
                end else begin
                    mepc_q   <= {next_pc[XLEN-1:2], 2'b00};
                    mcause_q <= irq_cause;
                    mtval_q  <= '0;
                end
            end else if (mret_acc) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (wr_acc) begin
                case (csr_waddr)
                    A_MSTATUS: begin
                        mst_mie  <= csr_wdata[3];
                        mst_mpie <= csr_wdata[7];
                    end
                    A_MIE:      mie_q      <= wval;
                    A_MTVEC:    mtvec_q    <= wval;
                    A_MSCRATCH: mscratch_q <= wval;
                    A_MEPC:     mepc_q     <= wval;
                    A_MCAUSE:   mcause_q   <= wval;
                    A_MTVAL:    mtval_q    <= wval;
                    default: ;
                endcase
            end

            if (wr_acc && csr_waddr == A_MCYCLE) mcycle_q <= csr_wdata;
            else                                 mcycle_q <= mcycle_q + XLEN'(1);

            if (wr_acc && csr_waddr == A_MINSTRET) minstret_q <= csr_wdata;
            else if (retire)                       minstret_q <= minstret_q + XLEN'(1);
        end
    end

`ifdef CSR_HPM_EN
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_HPM; i++) begin
            if (reset)                                         hpm_q[i] <= '0;
            else if (wr_acc && csr_waddr == A_HPM0 + 12'(i))   hpm_q[i] <= csr_wdata;
            else if (hpm_event[i])                             hpm_q[i] <= hpm_q[i] + XLEN'(1);
        end
    end
`else
    logic unused_hpm_event;
    assign unused_hpm_event = ^hpm_event;
`endif

endmodule

// File: tb/tb_csr_file_m.sv
// Bench for csr_file_m: directed scenarios plus a randomized run against a behavioural model.
// Default parameters (XLEN=64, NUM_HPM=4, RESET_MTVEC=0); honours CSR_HPM_EN when defined.
module tb_csr_file_m;
    localparam int XLEN = 64;
`ifdef CSR_HPM_EN
    localparam bit HPM_EN = 1'b1;
`else
    localparam bit HPM_EN = 1'b0;
`endif

    logic        clock, reset, csr_wen, commit, exc_valid, mret, irq_ext, irq_soft, irq_timer;
    logic [11:0] csr_waddr, csr_raddr;
    logic [63:0] csr_wdata, pc, next_pc, exc_tval;
    logic [4:0]  exc_cause;
    logic [3:0]  hpm_event;
    logic [63:0] csr_rdata, redirect_pc, mstatus_o, mie_o;
    logic        trap_take, redirect_valid, irq_pending;

    int total = 0;
    int bad   = 0;

    csr_file_m dut (
        .clock(clock), .reset(reset),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .pc(pc), .next_pc(next_pc), .commit(commit),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .mret(mret), .irq_ext(irq_ext), .irq_soft(irq_soft), .irq_timer(irq_timer),
        .hpm_event(hpm_event),
        .trap_take(trap_take), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .irq_pending(irq_pending), .mstatus_o(mstatus_o), .mie_o(mie_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    bit          m_ie, m_pie;
    logic [63:0] m_mie, m_tvec, m_scratch, m_epc, m_cause, m_tval, m_cycle, m_instret;
    logic [63:0] m_hpm [4];

    bit          e_trap, e_mret, e_wacc, e_rv, e_pend;
    int          e_code;
    logic [63:0] e_rpc, e_rdata, e_mstatus;

    task automatic model_reset();
        m_ie = 0; m_pie = 0;
        m_mie = 0; m_tvec = 0; m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0;
        m_cycle = 0; m_instret = 0;
        for (int i = 0; i < 4; i++) m_hpm[i] = 0;
    endtask

    function automatic logic [63:0] mdl_mip();
        return (64'(irq_ext) << 11) | (64'(irq_timer) << 7) | (64'(irq_soft) << 3);
    endfunction

    function automatic bit is_hpm(input logic [11:0] a);
        return HPM_EN && a >= 12'hB03 && a <= 12'hB06;
    endfunction

    function automatic logic [63:0] mdl_read(input logic [11:0] a);
        case (a)
            12'h300: return 64'h1800 | (64'(m_pie) << 7) | (64'(m_ie) << 3);
            12'h304: return m_mie;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return mdl_mip();
            12'hB00: return m_cycle;
            12'hB02: return m_instret;
            default: return is_hpm(a) ? m_hpm[int'(a - 12'hB03)] : 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] mdl_warl(input logic [11:0] a, input logic [63:0] d);
        case (a)
            12'h300: return 64'h1800 | (d & 64'h88);
            12'h304: return d & 64'h888;
            12'h305: return (d[1:0] >= 2) ? (d & ~64'h3) : d;
            12'h341: return d & ~64'h3;
            12'h340, 12'h342, 12'h343, 12'hB00, 12'hB02: return d;
            default: return is_hpm(a) ? d : 64'h0;
        endcase
    endfunction

    task automatic model_eval();
        logic [63:0] pend;
        bit irq;
        pend   = mdl_mip() & m_mie;
        e_pend = (pend != 0);
        e_code = pend[11] ? 11 : (pend[3] ? 3 : 7);
        irq    = !reset && commit && !exc_valid && m_ie && e_pend;
        e_trap = !reset && (exc_valid || irq);
        e_mret = !reset && mret && !e_trap;
        e_wacc = !reset && csr_wen && !e_trap && !e_mret;
        e_rv   = e_trap || e_mret;
        if (e_trap)
            e_rpc = (!exc_valid && m_tvec[1:0] == 2'd1) ? (m_tvec & ~64'h3) + 64'(4 * e_code)
                                                        : (m_tvec & ~64'h3);
        else
            e_rpc = (csr_wen && csr_waddr == 12'h341) ? (csr_wdata & ~64'h3) : m_epc;
        e_rdata   = (e_wacc && csr_waddr == csr_raddr && csr_raddr != 12'h344)
                    ? mdl_warl(csr_waddr, csr_wdata) : mdl_read(csr_raddr);
        e_mstatus = mdl_read(12'h300);
    endtask

    task automatic model_commit();
        logic [63:0] v;
        model_eval();
        if (reset) begin
            model_reset();
            return;
        end
        if (e_trap) begin
            m_pie = m_ie;
            m_ie  = 0;
            if (exc_valid) begin
                m_epc = pc & ~64'h3; m_cause = 64'(exc_cause); m_tval = exc_tval;
            end else begin
                m_epc = next_pc & ~64'h3; m_cause = (64'h1 << 63) + 64'(e_code); m_tval = 0;
            end
        end else if (e_mret) begin
            m_ie  = m_pie;
            m_pie = 1;
        end
        // Counters count first; an accepted write then overrides the result.
        m_cycle = m_cycle + 1;
        if (commit && !exc_valid) m_instret = m_instret + 1;
        for (int i = 0; i < 4; i++) if (HPM_EN && hpm_event[i]) m_hpm[i] = m_hpm[i] + 1;
        if (e_wacc) begin
            v = mdl_warl(csr_waddr, csr_wdata);
            case (csr_waddr)
                12'h300: begin m_ie = v[3]; m_pie = v[7]; end
                12'h304: m_mie = v;
                12'h305: m_tvec = v;
                12'h340: m_scratch = v;
                12'h341: m_epc = v;
                12'h342: m_cause = v;
                12'h343: m_tval = v;
                12'hB00: m_cycle = v;
                12'hB02: m_instret = v;
                default: if (is_hpm(csr_waddr)) m_hpm[int'(csr_waddr - 12'hB03)] = v;
            endcase
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        model_commit();
        @(negedge clock);
    endtask

    task automatic set_idle();
        csr_wen = 0; csr_waddr = 0; csr_wdata = 0; csr_raddr = 0;
        pc = 0; next_pc = 0; commit = 0; exc_valid = 0; exc_cause = 0; exc_tval = 0;
        mret = 0; irq_ext = 0; irq_soft = 0; irq_timer = 0; hpm_event = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        csr_wen = 1; csr_waddr = a; csr_wdata = d;
        tick();
        csr_wen = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        reset = 1; exc_valid = 1; commit = 1; mret = 1;
        #1;
        total++; if (trap_take !== 1'b0) begin bad++; $display("FAIL reset_trap_take got=%b exp=0", trap_take); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", redirect_valid); end
        tick(); tick();
        set_idle(); reset = 0;
        csr_raddr = 12'h300; #1;
        total++; if (csr_rdata !== 64'h1800) begin bad++; $display("FAIL reset_mstatus got=%h exp=%h", csr_rdata, 64'h1800); end
        csr_raddr = 12'h305; #1;
        total++; if (csr_rdata !== 64'h0) begin bad++; $display("FAIL reset_mtvec got=%h exp=0", csr_rdata); end
        total++; if (mie_o !== 64'h0) begin bad++; $display("FAIL reset_mie got=%h exp=0", mie_o); end
        repeat (10) tick();
        csr_raddr = 12'hB00; #1;
        total++; if (csr_rdata !== 64'd10) begin bad++; $display("FAIL reset_mcycle got=%0d exp=10", csr_rdata); end
    endtask

    task automatic test_timer_irq();
        wr(12'h305, 64'h8000_0001);
        wr(12'h304, 64'h80);
        wr(12'h300, 64'h8);
        irq_timer = 1; commit = 1; pc = 64'h1000; next_pc = 64'h1004; #1;
        total++; if (trap_take !== 1'b1) begin bad++; $display("FAIL timer_trap_take got=%b exp=1", trap_take); end
        total++; if (redirect_pc !== 64'h8000_001C) begin bad++; $display("FAIL timer_redirect got=%h exp=%h", redirect_pc, 64'h8000_001C); end
        tick();
        irq_timer = 0; commit = 0;
        csr_raddr = 12'h341; #1;
        total++; if (csr_rdata !== 64'h1004) begin bad++; $display("FAIL timer_mepc got=%h exp=%h", csr_rdata, 64'h1004); end
        csr_raddr = 12'h342; #1;
        total++; if (csr_rdata !== 64'h8000_0000_0000_0007) begin bad++; $display("FAIL timer_mcause got=%h exp=%h", csr_rdata, 64'h8000_0000_0000_0007); end
        total++; if (mstatus_o !== 64'h1880) begin bad++; $display("FAIL timer_mstatus got=%h exp=%h", mstatus_o, 64'h1880); end
    endtask

    task automatic test_mret();
        mret = 1; #1;
        total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL mret_valid got=%b exp=1", redirect_valid); end
        total++; if (redirect_pc !== 64'h1004) begin bad++; $display("FAIL mret_pc got=%h exp=%h", redirect_pc, 64'h1004); end
        tick();
        mret = 0; #1;
        total++; if (mstatus_o !== 64'h1888) begin bad++; $display("FAIL mret_mstatus got=%h exp=%h", mstatus_o, 64'h1888); end
        mret = 1; csr_wen = 1; csr_waddr = 12'h341; csr_wdata = 64'h2000; #1;
        total++; if (redirect_pc !== 64'h2000) begin bad++; $display("FAIL mret_fwd_pc got=%h exp=%h", redirect_pc, 64'h2000); end
        tick();
        mret = 0; csr_wen = 0; csr_raddr = 12'h341; #1;
        total++; if (csr_rdata !== 64'h1004) begin bad++; $display("FAIL mret_write_dropped got=%h exp=%h", csr_rdata, 64'h1004); end
    endtask

    task automatic test_priority();
        logic [63:0] instret_before;
        wr(12'h304, 64'h880);
        irq_ext = 1; irq_timer = 1; commit = 1; pc = 64'h2000; next_pc = 64'h2004; #1;
        total++; if (redirect_pc !== 64'h8000_002C) begin bad++; $display("FAIL prio_vec_pc got=%h exp=%h", redirect_pc, 64'h8000_002C); end
        tick();
        commit = 0; csr_raddr = 12'h342; #1;
        total++; if (csr_rdata !== 64'h8000_0000_0000_000B) begin bad++; $display("FAIL prio_mcause got=%h exp=%h", csr_rdata, 64'h8000_0000_0000_000B); end
        mret = 1; tick(); mret = 0;
        instret_before = m_instret;
        commit = 1; exc_valid = 1; exc_cause = 5'd2; pc = 64'h3000; exc_tval = 64'hDEAD; #1;
        total++; if (trap_take !== 1'b1) begin bad++; $display("FAIL prio_exc_take got=%b exp=1", trap_take); end
        total++; if (redirect_pc !== 64'h8000_0000) begin bad++; $display("FAIL prio_exc_pc got=%h exp=%h", redirect_pc, 64'h8000_0000); end
        tick();
        set_idle(); csr_raddr = 12'h342; #1;
        total++; if (csr_rdata !== 64'h2) begin bad++; $display("FAIL prio_exc_mcause got=%h exp=2", csr_rdata); end
        csr_raddr = 12'h341; #1;
        total++; if (csr_rdata !== 64'h3000) begin bad++; $display("FAIL prio_exc_mepc got=%h exp=%h", csr_rdata, 64'h3000); end
        csr_raddr = 12'hB02; #1;
        total++; if (csr_rdata !== instret_before) begin bad++; $display("FAIL prio_minstret got=%h exp=%h", csr_rdata, instret_before); end
    endtask

    task automatic test_warl_fwd();
        wr(12'h305, 64'h3);
        csr_raddr = 12'h305; #1;
        total++; if (csr_rdata !== 64'h0) begin bad++; $display("FAIL warl_mtvec got=%h exp=0", csr_rdata); end
        wr(12'h341, 64'h1003);
        csr_raddr = 12'h341; #1;
        total++; if (csr_rdata !== 64'h1000) begin bad++; $display("FAIL warl_mepc got=%h exp=%h", csr_rdata, 64'h1000); end
        csr_wen = 1; csr_waddr = 12'h340; csr_raddr = 12'h340; csr_wdata = 64'h55; #1;
        total++; if (csr_rdata !== 64'h55) begin bad++; $display("FAIL fwd_mscratch got=%h exp=%h", csr_rdata, 64'h55); end
        tick();
        irq_soft = 1; csr_waddr = 12'h344; csr_raddr = 12'h344; csr_wdata = 64'hFFFF; #1;
        total++; if (csr_rdata !== 64'h8) begin bad++; $display("FAIL fwd_mip got=%h exp=%h", csr_rdata, 64'h8); end
        tick();
        set_idle();
    endtask

    task automatic test_counters();
        wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_raddr = 12'hB00; #1;
        total++; if (csr_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL mcycle_written got=%h", csr_rdata); end
        tick(); #1;
        total++; if (csr_rdata !== 64'h0) begin bad++; $display("FAIL mcycle_wrap got=%h exp=0", csr_rdata); end
        hpm_event = 4'b0001;
        repeat (3) tick();
        hpm_event = 0; csr_raddr = 12'hB03; #1;
        total++; if (csr_rdata !== (HPM_EN ? 64'd3 : 64'd0)) begin bad++; $display("FAIL hpm0_count got=%0d exp=%0d", csr_rdata, HPM_EN ? 3 : 0); end
    endtask

    task automatic test_reset_mid_trap();
        exc_valid = 1; commit = 1; exc_cause = 5'd4; pc = 64'h4444; reset = 1; #1;
        total++; if (trap_take !== 1'b0) begin bad++; $display("FAIL midrst_trap got=%b exp=0", trap_take); end
        tick();
        set_idle(); reset = 0; csr_raddr = 12'h341; #1;
        total++; if (csr_rdata !== 64'h0) begin bad++; $display("FAIL midrst_mepc got=%h exp=0", csr_rdata); end
        csr_raddr = 12'h342; #1;
        total++; if (csr_rdata !== 64'h0) begin bad++; $display("FAIL midrst_mcause got=%h exp=0", csr_rdata); end
        total++; if (mstatus_o !== 64'h1800) begin bad++; $display("FAIL midrst_mstatus got=%h exp=%h", mstatus_o, 64'h1800); end
    endtask

    task automatic test_random();
        logic [11:0] addrs [16];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                  12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB04, 12'hB06, 12'hB07, 12'h123};
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            csr_wen   = ($urandom_range(0, 1) == 1);
            csr_waddr = addrs[$urandom_range(0, 15)];
            csr_raddr = ($urandom_range(0, 2) == 0) ? csr_waddr : addrs[$urandom_range(0, 15)];
            csr_wdata = {$urandom, $urandom};
            pc        = {$urandom, $urandom};
            next_pc   = {$urandom, $urandom};
            commit    = ($urandom_range(0, 1) == 1);
            exc_valid = ($urandom_range(0, 9) == 0);
            exc_cause = 5'($urandom);
            exc_tval  = {$urandom, $urandom};
            mret      = ($urandom_range(0, 7) == 0);
            irq_ext   = ($urandom_range(0, 3) == 0);
            irq_soft  = ($urandom_range(0, 3) == 0);
            irq_timer = ($urandom_range(0, 3) == 0);
            hpm_event = 4'($urandom);
            #1;
            model_eval();
            total++; if (trap_take !== e_trap) begin bad++; $display("FAIL rnd_trap c=%0d got=%b exp=%b", c, trap_take, e_trap); end
            total++; if (redirect_valid !== e_rv) begin bad++; $display("FAIL rnd_rv c=%0d got=%b exp=%b", c, redirect_valid, e_rv); end
            if (e_rv) begin
                total++; if (redirect_pc !== e_rpc) begin bad++; $display("FAIL rnd_rpc c=%0d got=%h exp=%h", c, redirect_pc, e_rpc); end
            end
            total++; if (csr_rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata c=%0d addr=%h got=%h exp=%h", c, csr_raddr, csr_rdata, e_rdata); end
            total++; if (irq_pending !== e_pend) begin bad++; $display("FAIL rnd_pend c=%0d got=%b exp=%b", c, irq_pending, e_pend); end
            total++; if (mstatus_o !== e_mstatus) begin bad++; $display("FAIL rnd_mstatus c=%0d got=%h exp=%h", c, mstatus_o, e_mstatus); end
            total++; if (mie_o !== m_mie) begin bad++; $display("FAIL rnd_mie c=%0d got=%h exp=%h", c, mie_o, m_mie); end
            tick();
        end
        reset = 0;
        set_idle();
    endtask

    initial begin
        model_reset();
        reset = 1;
        set_idle();
        test_reset();
        test_timer_irq();
        test_mret();
        test_priority();
        test_warl_fwd();
        test_counters();
        test_reset_mid_trap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
